// File: rtl/grid_click_locator.sv
// grid_click_locator: resolves a mouse press to the column/row of a regular
// grid of boxes. On a press edge the pointer position is captured, columns
// are scanned one per cycle, then rows, and a one-cycle clickValid pulse
// publishes BoxX/BoxY/hit.
module grid_click_locator #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int X_ORIGIN = 16,
    parameter int X_PITCH  = 37,
    parameter int BOX_W    = 21,
    parameter int Y_ORIGIN = 7,
    parameter int Y_PITCH  = 28,
    parameter int BOX_H    = 21
) (
    input  logic                                           clk,
    input  logic                                           iReset,
    input  logic [X_W-1:0]                                 mouseX,
    input  logic [Y_W-1:0]                                 mouseY,
    input  logic                                           button,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]     BoxX,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]     BoxY,
    output logic                                           hit,
    output logic                                           clickValid,
    output logic                                           busy
);

    localparam int CXW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CYW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Far edge of the last box; bounds must hold it and the X_W+1 compare width
    localparam int X_LAST = X_ORIGIN + (COLS - 1) * X_PITCH + BOX_W;
    localparam int Y_LAST = Y_ORIGIN + (ROWS - 1) * Y_PITCH + BOX_H;
    localparam int XBW    = ($clog2(X_LAST + 1) > X_W + 1) ? $clog2(X_LAST + 1) : X_W + 1;
    localparam int YBW    = ($clog2(Y_LAST + 1) > Y_W + 1) ? $clog2(Y_LAST + 1) : Y_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN_X, SCAN_Y, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             btn_prev;
    logic             press;
    logic [X_W-1:0]   cap_x;
    logic [Y_W-1:0]   cap_y;
    logic [CXW-1:0]   col;
    logic [CYW-1:0]   row;
    logic [XBW-1:0]   left;
    logic [YBW-1:0]   top;
    logic             x_hit;
    logic             x_match;
    logic             y_match;
    logic             col_last;
    logic             row_last;

    assign press    = button && !btn_prev;
    assign x_match  = (XBW'(cap_x) > left) && (XBW'(cap_x) < left + XBW'(BOX_W));
    assign y_match  = (YBW'(cap_y) > top)  && (YBW'(cap_y) < top + YBW'(BOX_H));
    assign col_last = (col == CXW'(COLS - 1));
    assign row_last = (row == CYW'(ROWS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!iReset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state: one column per cycle, then one row per cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = SCAN_X;
            SCAN_X:  if (x_match || col_last) state_next = SCAN_Y;
            SCAN_Y:  if (y_match || row_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy       = (state != IDLE);
        clickValid = (state == DONE);
    end

    // Capture, scan counters/bounds and result registers
    always_ff @(posedge clk) begin
        if (!iReset) begin
            btn_prev <= 1'b0;
            cap_x    <= '0;
            cap_y    <= '0;
            col      <= '0;
            row      <= '0;
            left     <= '0;
            top      <= '0;
            x_hit    <= 1'b0;
            BoxX     <= '0;
            BoxY     <= '0;
            hit      <= 1'b0;
        end else begin
            btn_prev <= button;
            case (state)
                IDLE: begin
                    if (press) begin
                        cap_x <= mouseX;
                        cap_y <= mouseY;
                        col   <= '0;
                        left  <= XBW'(X_ORIGIN);
                    end
                end
                SCAN_X: begin
                    // col is left at the matched index and read back on entry to DONE
                    if (x_match || col_last) begin
                        x_hit <= x_match;
                        row   <= '0;
                        top   <= YBW'(Y_ORIGIN);
                    end else begin
                        col  <= col + CXW'(1);
                        left <= left + XBW'(X_PITCH);
                    end
                end
                SCAN_Y: begin
                    if (y_match || row_last) begin
                        hit  <= x_hit && y_match;
                        BoxX <= (x_hit && y_match) ? col : '0;
                        BoxY <= (x_hit && y_match) ? row : '0;
                    end else begin
                        row <= row + CYW'(1);
                        top <= top + YBW'(Y_PITCH);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_click_locator.sv
// Bench for grid_click_locator: directed and random clicks on a default-sized
// grid and on a 4x3 grid, checked against a geometric reference model.
// Latency is counted from the clock edge just before the press to the edge at
// which a downstream register would capture clickValid.
module tb_grid_click_locator;

    logic       clk = 1'b0;
    logic       iReset = 1'b0;

    logic [9:0] mx_d = '0;
    logic [8:0] my_d = '0;
    logic       btn_d = 1'b0;
    logic [2:0] bx_d;
    logic [2:0] by_d;
    logic       hit_d, cv_d, busy_d;

    logic [7:0] mx_s = '0;
    logic [7:0] my_s = '0;
    logic       btn_s = 1'b0;
    logic [1:0] bx_s;
    logic [1:0] by_s;
    logic       hit_s, cv_s, busy_s;

    int vectors = 0;
    int errors  = 0;
    int pulses_d = 0;
    int pulses_s = 0;

    always #5 clk = ~clk;

    grid_click_locator u_def (
        .clk(clk), .iReset(iReset), .mouseX(mx_d), .mouseY(my_d), .button(btn_d),
        .BoxX(bx_d), .BoxY(by_d), .hit(hit_d), .clickValid(cv_d), .busy(busy_d)
    );

    grid_click_locator #(.COLS(4), .ROWS(3), .X_W(8), .Y_W(8)) u_small (
        .clk(clk), .iReset(iReset), .mouseX(mx_s), .mouseY(my_s), .button(btn_s),
        .BoxX(bx_s), .BoxY(by_s), .hit(hit_s), .clickValid(cv_s), .busy(busy_s)
    );

    // Count clickValid cycles independently of the directed sequence
    always @(negedge clk) begin
        if (cv_d) pulses_d++;
        if (cv_s) pulses_s++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Geometric model: first box whose open interval contains the point
    function automatic void ref_click(input bit sel, input int x, input int y,
                                      output int bx, output int by, output int h, output int lat);
        int cols, rows, fx, fy;
        cols = sel ? 4 : 8;
        rows = sel ? 3 : 8;
        fx = -1;
        fy = -1;
        for (int c = 0; c < cols; c++)
            if (fx < 0 && x > 16 + c * 37 && x < 16 + c * 37 + 21) fx = c;
        for (int r = 0; r < rows; r++)
            if (fy < 0 && y > 7 + r * 28 && y < 7 + r * 28 + 21) fy = r;
        h   = (fx >= 0 && fy >= 0) ? 1 : 0;
        bx  = h ? fx : 0;
        by  = h ? fy : 0;
        lat = ((fx >= 0) ? fx + 1 : cols) + ((fy >= 0) ? fy + 1 : rows) + 2;
    endfunction

    // Wait for the result of a press already applied just after a clock edge
    task automatic await_result(input bit sel, input int x, input int y, input bit scramble);
        int bx, by, h, lat, k, p0;
        bit seen;
        ref_click(sel, x, y, bx, by, h, lat);
        p0 = sel ? pulses_s : pulses_d;
        seen = 0;
        k = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (i == 1) check("busy_scan", sel ? busy_s : busy_d, 1);
            if (scramble) begin
                mx_d = 10'($urandom); my_d = 9'($urandom);
                mx_s = 8'($urandom);  my_s = 8'($urandom);
            end
            if (sel ? cv_s : cv_d) begin seen = 1; k = i; end
        end
        check("latency", seen ? k + 1 : -1, lat);
        check("BoxX", sel ? int'(bx_s) : int'(bx_d), bx);
        check("BoxY", sel ? int'(by_s) : int'(by_d), by);
        check("hit", sel ? int'(hit_s) : int'(hit_d), h);
        btn_d = 1'b0;
        btn_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("one_pulse", (sel ? pulses_s : pulses_d) - p0, 1);
        check("held_BoxX", sel ? int'(bx_s) : int'(bx_d), bx);
        check("held_hit", sel ? int'(hit_s) : int'(hit_d), h);
        check("idle_busy", sel ? busy_s : busy_d, 0);
    endtask

    task automatic click(input bit sel, input int x, input int y, input bit scramble);
        @(posedge clk); #1;
        if (sel) begin mx_s = 8'(x); my_s = 8'(y); btn_s = 1'b1; end
        else     begin mx_d = 10'(x); my_d = 9'(y); btn_d = 1'b1; end
        await_result(sel, x, y, scramble);
    endtask

    initial begin
        int p0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_BoxX", bx_d, 0);
        check("rst_BoxY", by_d, 0);
        check("rst_hit", hit_d, 0);
        check("rst_cv", cv_d, 0);
        check("rst_busy", busy_d, 0);
        iReset = 1'b1;
        repeat (2) @(posedge clk);

        // Directed clicks: first box, last box, strict-edge misses, scrambled coordinates
        click(0, 20, 10, 0);
        click(0, 290, 210, 0);
        click(0, 37, 40, 0);
        click(0, 16, 40, 0);
        click(0, 60, 40, 1);

        // Held button with a re-press while busy: one result only
        p0 = pulses_d;
        @(posedge clk); #1;
        mx_d = 10'd60; my_d = 9'd40; btn_d = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_d = 1'b0;
        @(posedge clk);
        #1 btn_d = 1'b1;
        repeat (100) @(posedge clk);
        #1 btn_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_pulses", pulses_d - p0, 1);
        check("hold_BoxX", bx_d, 1);

        // Reset during SCAN_Y after a prior hit aborts without a result
        p0 = pulses_d;
        @(posedge clk); #1;
        mx_d = 10'd290; my_d = 9'd210; btn_d = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", busy_d, 1);
        iReset = 1'b0;
        @(posedge clk); #1;
        check("abort_BoxX", bx_d, 0);
        check("abort_BoxY", by_d, 0);
        check("abort_hit", hit_d, 0);
        check("abort_cv", cv_d, 0);
        check("abort_busy", busy_d, 0);
        mx_d = 10'd20; my_d = 9'd10;
        @(posedge clk); #1;
        check("abort_pulses", pulses_d - p0, 0);
        // Button still high as reset releases: counts as a fresh press
        iReset = 1'b1;
        await_result(0, 20, 10, 0);

        // Random clicks on the default grid
        for (int n = 0; n < 12; n++)
            click(0, $urandom_range(0, 330), $urandom_range(0, 240), n[0]);

        // Reduced 4x3 grid
        click(1, 130, 70, 0);
        for (int n = 0; n < 6; n++)
            click(1, $urandom_range(0, 170), $urandom_range(0, 100), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
